// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch BCD counter.
//   sw_state_t   : control FSM state encoding
//   BCD_MAX      : last value of a decimal digit (9)
//   TENS_SEC_MAX : last value of the tens-of-seconds digit (5)
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] TENS_SEC_MAX = 4'd5;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the stopwatch. Counts 0..MAX on inc and wraps to 0,
// raising carry in the same cycle so the next digit advances together.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (wins over inc)
//   inc        : advance by one this cycle
//   digit[3:0] : current digit value
//   carry      : inc & (digit == MAX)
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  assign carry = inc & (digit == MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= 4'd0;
    end else if (clr) begin
      digit <= 4'd0;
    end else if (inc) begin
      digit <= (digit == MAX) ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch time base and M:SS.T BCD digit counter feeding the 7-segment
// decoders. A prescaler produces a tick every TENTH_DIV cycles while running;
// each tick advances the four cascaded digits.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   start_stop       : start/stop request, acted on at its rising edge
//   clear            : synchronous level clear back to IDLE / 0:00.0
//   minutes, tens_seconds, ones_seconds, tenths_seconds : BCD digits
//   running          : high while in RUN
//   ovf              : overflow indication
// Build option STOPWATCH_WRAP_EN:
//   defined   -> 9:59.9 + tick wraps to 0:00.0, stays in RUN, ovf one-cycle pulse
//   undefined -> count holds at 9:59.9, FSM pauses, ovf sticky; start_stop is
//                ignored until clear or reset
//
// state | meaning
// IDLE  | cleared, digits 0:00.0, prescaler 0
// RUN   | prescaler counting, digits advance on tick
// PAUSE | prescaler and digits frozen (partial tenth kept)
module stopwatch_bcd_counter
  import stopwatch_pkg::*;
#(
  parameter int TENTH_DIV = 10_000_000,
  parameter int PRESC_W   = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] minutes,
  output logic [3:0] tens_seconds,
  output logic [3:0] ones_seconds,
  output logic [3:0] tenths_seconds,
  output logic       running,
  output logic       ovf
);

  localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(TENTH_DIV - 1);

  sw_state_t          state, next_state;
  logic               start_stop_q;
  logic               ss_edge;
  logic [PRESC_W-1:0] presc;
  logic               tick;
  logic               at_max;
  logic               terminal;
  logic               tenths_inc;
  logic               c_tenths, c_ones, c_tens;
  logic               min_carry_unused;

  assign ss_edge  = start_stop & ~start_stop_q;
  assign tick     = (state == RUN) && (presc == PRESC_TC);
  assign at_max   = (tenths_seconds == BCD_MAX) && (ones_seconds == BCD_MAX) &&
                    (tens_seconds == TENS_SEC_MAX) && (minutes == BCD_MAX);
  assign terminal = tick & at_max;

`ifdef STOPWATCH_WRAP_EN
  assign tenths_inc = tick & ~clear;
`else
  // The terminal tick must not roll the digits; they hold at 9:59.9.
  assign tenths_inc = tick & ~clear & ~at_max;
`endif

  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:  if (ss_edge) next_state = RUN;
`ifdef STOPWATCH_WRAP_EN
        RUN:   if (ss_edge) next_state = PAUSE;
        PAUSE: if (ss_edge) next_state = RUN;
`else
        RUN:   if (terminal || ss_edge) next_state = PAUSE;
        PAUSE: if (ss_edge && !ovf) next_state = RUN;
`endif
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      start_stop_q <= 1'b0;
      running      <= 1'b0;
      presc        <= '0;
      ovf          <= 1'b0;
    end else begin
      state        <= next_state;
      start_stop_q <= start_stop;
      running      <= (next_state == RUN);

      if (clear || state == IDLE) begin
        presc <= '0;
      end else if (state == RUN) begin
        presc <= tick ? '0 : presc + 1'b1;
      end

`ifdef STOPWATCH_WRAP_EN
      ovf <= terminal & ~clear;
`else
      if (clear) begin
        ovf <= 1'b0;
      end else if (terminal) begin
        ovf <= 1'b1;
      end
`endif
    end
  end

  bcd_digit_counter #(.MAX(BCD_MAX)) u_tenths (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(tenths_inc),
    .digit(tenths_seconds), .carry(c_tenths)
  );

  bcd_digit_counter #(.MAX(BCD_MAX)) u_ones (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(c_tenths),
    .digit(ones_seconds), .carry(c_ones)
  );

  bcd_digit_counter #(.MAX(TENS_SEC_MAX)) u_tens (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(c_ones),
    .digit(tens_seconds), .carry(c_tens)
  );

  // Minutes carry-out has no consumer; terminal count is decoded from at_max.
  bcd_digit_counter #(.MAX(BCD_MAX)) u_minutes (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(c_tens),
    .digit(minutes), .carry(min_carry_unused)
  );

endmodule
